// File: rtl/streamgen.sv
// streamgen: AXI-Stream packet source emitting num_packets packets of packet_len incrementing words,
// with optional idle gaps, abort at packet boundaries, and byte/packet totals for the run.
module streamgen #(
  parameter int C_AXIS_BYTEWIDTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          start,
  input  logic                          abort,
  input  logic [15:0]                   packet_len,
  input  logic [15:0]                   num_packets,
  input  logic [7:0]                    gap_cycles,
  output logic                          output_m_axis_tvalid,
  output logic [C_AXIS_BYTEWIDTH*8-1:0] output_m_axis_tdata,
  output logic [C_AXIS_BYTEWIDTH-1:0]   output_m_axis_tstrb,
  output logic                          output_m_axis_tlast,
  input  logic                          output_m_axis_tready,
  output logic                          busy,
  output logic                          done,
  output logic [31:0]                   byte_count,
  output logic [31:0]                   packet_count
);
  localparam int W = C_AXIS_BYTEWIDTH * 8;
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t state, state_n;
  logic [15:0] len_q, num_q, beat;
  logic [7:0]  gap_q, gap_cnt;
  logic [31:0] word;
  logic        abort_q, xfer, last, fin, stop, start_ok;
  assign last     = beat == len_q - 16'd1;
  assign xfer     = state == SEND && output_m_axis_tready;
  assign fin      = packet_count + 32'd1 == {16'd0, num_q};
  assign stop     = abort_q | abort;
  assign start_ok = state == IDLE && start && packet_len != 16'd0 && num_packets != 16'd0;
  assign output_m_axis_tvalid = state == SEND;
  assign output_m_axis_tlast  = state == SEND && last;
  assign output_m_axis_tdata  = W'(word);
  assign output_m_axis_tstrb  = '1;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start_ok ? SEND : IDLE;
      SEND:    state_n = !(xfer && last) ? SEND : (fin || stop) ? IDLE : gap_q == 8'd0 ? SEND : GAP;
      GAP:     state_n = gap_cnt != 8'd0 ? GAP : stop ? IDLE : SEND;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      len_q <= '0; num_q <= '0; gap_q <= '0; gap_cnt <= '0; beat <= '0; word <= '0;
      abort_q <= 1'b0; done <= 1'b0; byte_count <= '0; packet_count <= '0;
    end else begin
      done <= state != IDLE && state_n == IDLE;
      if (start_ok) begin
        len_q <= packet_len; num_q <= num_packets; gap_q <= gap_cycles;
        byte_count <= '0; packet_count <= '0; word <= '0; beat <= '0; abort_q <= 1'b0;
      end else begin
        if (state != IDLE && abort) abort_q <= 1'b1;
        if (xfer) begin
          byte_count <= byte_count + 32'(C_AXIS_BYTEWIDTH);
          word <= word + 32'd1;
          beat <= last ? 16'd0 : beat + 16'd1;
          if (last) packet_count <= packet_count + 32'd1;
        end
        // gap counter counts down to 0, giving exactly gap_cycles idle cycles
        if (state == SEND && state_n == GAP) gap_cnt <= gap_q - 8'd1;
        else if (state == GAP) gap_cnt <= gap_cnt - 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_streamgen.sv
// tb_streamgen: directed self-checking bench for streamgen (data/tlast order, gaps, abort, reset, ignored starts).
module tb_streamgen;
  logic clk, resetn, start, abort, tready;
  logic [15:0] packet_len, num_packets;
  logic [7:0] gap_cycles;
  logic tvalid, tlast, busy, done;
  logic [31:0] tdata, byte_count, packet_count;
  logic [3:0] tstrb;
  int total, bad;
  logic [31:0] q_data[$];
  logic q_last[$];
  int q_step[$];
  int done_step;

  streamgen dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .packet_len(packet_len), .num_packets(num_packets), .gap_cycles(gap_cycles),
    .output_m_axis_tvalid(tvalid), .output_m_axis_tdata(tdata), .output_m_axis_tstrb(tstrb),
    .output_m_axis_tlast(tlast), .output_m_axis_tready(tready),
    .busy(busy), .done(done), .byte_count(byte_count), .packet_count(packet_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [15:0] len, input logic [15:0] num, input logic [7:0] gap);
    packet_len = len; num_packets = num; gap_cycles = gap; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // Runs until done, logging every accepted beat; checks hold-stability under backpressure.
  task automatic collect(input int budget, input bit rnd, input int abort_at, input int start_at);
    bit hold, fin;
    logic [31:0] hd;
    logic hl;
    q_data.delete(); q_last.delete(); q_step.delete();
    done_step = -1; hold = 0; fin = 0; hd = '0; hl = 0;
    for (int t = 0; t < budget && !fin; t++) begin
      if (hold) begin
        chk("hold_valid", 32'(tvalid), 32'd1);
        chk("hold_data", tdata, hd);
        chk("hold_last", 32'(tlast), 32'(hl));
      end
      if (done) begin
        done_step = t;
        fin = 1;
      end else begin
        tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        abort = abort_at >= 0 && q_data.size() == abort_at && tvalid;
        start = start_at >= 0 && q_data.size() == start_at && tvalid;
        hold = tvalid && !tready; hd = tdata; hl = tlast;
        if (tvalid && tready) begin
          q_data.push_back(tdata); q_last.push_back(tlast); q_step.push_back(t);
        end
        cycle();
      end
    end
    if (!fin) chk("done_timeout", 32'd0, 32'd1);
    abort = 0; start = 0; tready = 1;
  endtask

  task automatic verify(input string tag, input int n, input int len);
    chk({tag, "_beats"}, 32'(q_data.size()), 32'(n));
    for (int i = 0; i < q_data.size() && i < n; i++) begin
      chk({tag, "_data"}, q_data[i], 32'(i));
      chk({tag, "_last"}, 32'(q_last[i]), 32'(i % len == len - 1));
    end
  endtask

  task automatic after_done(input string tag, input logic [31:0] bytes, input logic [31:0] pkts);
    if (q_step.size() > 0) chk({tag, "_done_lat"}, 32'(done_step - q_step[q_step.size()-1]), 32'd1);
    chk({tag, "_bytes"}, byte_count, bytes);
    chk({tag, "_pkts"}, packet_count, pkts);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    cycle();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle_valid"}, 32'(tvalid), 32'd0);
    chk({tag, "_bytes_hold"}, byte_count, bytes);
  endtask

  initial begin
    total = 0; bad = 0;
    resetn = 0; start = 0; abort = 0; tready = 1;
    packet_len = 0; num_packets = 0; gap_cycles = 0;
    #12;
    chk("rst_valid", 32'(tvalid), 32'd0);
    chk("rst_last", 32'(tlast), 32'd0);
    chk("rst_data", tdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bytes", byte_count, 32'd0);
    chk("rst_pkts", packet_count, 32'd0);
    chk("rst_strb", 32'(tstrb), 32'hF);
    resetn = 1;
    cycle();

    // 1: basic run, always ready
    go(16'd4, 16'd2, 8'd0);
    chk("t1_latency_valid", 32'(tvalid), 32'd1);
    chk("t1_first_data", tdata, 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    collect(100, 0, -1, -1);
    verify("t1", 8, 4);
    chk("t1_no_bubble", 32'(q_step[7] - q_step[0]), 32'd7);
    after_done("t1", 32'd32, 32'd2);

    // 2: same run with random backpressure
    go(16'd4, 16'd2, 8'd0);
    collect(400, 1, -1, -1);
    verify("t2", 8, 4);
    after_done("t2", 32'd32, 32'd2);

    // 3: single-beat packets separated by two idle cycles
    go(16'd1, 16'd3, 8'd2);
    collect(100, 0, -1, -1);
    verify("t3", 3, 1);
    if (q_step.size() == 3) begin
      chk("t3_gap0", 32'(q_step[1] - q_step[0]), 32'd3);
      chk("t3_gap1", 32'(q_step[2] - q_step[1]), 32'd3);
    end
    after_done("t3", 32'd12, 32'd3);

    // 4: abort during packet 1 still completes that packet
    go(16'd8, 16'd10, 8'd0);
    collect(300, 0, 10, -1);
    verify("t4", 16, 8);
    after_done("t4", 32'd64, 32'd2);

    // 5: reset mid-packet, then restart from word 0
    go(16'd8, 16'd1, 8'd0);
    repeat (5) cycle();
    chk("t5_pre_data", tdata, 32'd5);
    resetn = 0;
    #1;
    chk("t5_valid", 32'(tvalid), 32'd0);
    chk("t5_data", tdata, 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_bytes", byte_count, 32'd0);
    chk("t5_pkts", packet_count, 32'd0);
    #3 resetn = 1;
    cycle();
    chk("t5_stays_idle", 32'(tvalid), 32'd0);
    go(16'd2, 16'd1, 8'd0);
    chk("t5_restart_data", tdata, 32'd0);
    collect(100, 0, -1, -1);
    verify("t5", 2, 2);
    after_done("t5", 32'd8, 32'd1);

    // 6: zero-length start ignored; start while busy ignored
    go(16'd0, 16'd3, 8'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t6_zero_busy", 32'(busy), 32'd0);
      chk("t6_zero_valid", 32'(tvalid), 32'd0);
      chk("t6_zero_done", 32'(done), 32'd0);
      cycle();
    end
    go(16'd3, 16'd2, 8'd1);
    packet_len = 16'd1; num_packets = 16'd5; gap_cycles = 8'd0;
    collect(100, 0, -1, 1);
    verify("t6", 6, 3);
    after_done("t6", 32'd24, 32'd2);
    repeat (3) begin
      chk("t6_no_rerun", 32'(busy), 32'd0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
